up_down_detector: RTL and testbench
===================================

// Module: up_down_detector
//
// PURPOSE
//  Receive-side companion to the board up/down counter. Samples a WIDTH-bit count stream
//  and infers the counting direction from successive samples. Locks onto UP or DOWN after
//  LOCK_CNT consistent steps and drives the 7-seg direction glyph ('U'/'d').
//  Flags illegal steps (jumps). Sits between the counter outputs (LEDs/pins) and the
//  display of a second board.
//
// PARAMETERS
//  WIDTH     4  count width; all step arithmetic is modulo 2**WIDTH
//  LOCK_CNT  3  consecutive same-direction steps required to lock (range 1..15)
//
// PORTS
//  clk       in   1      rising-edge clock
//  clr       in   1      asynchronous, active-high reset
//  valid     in   1      cnt_in is a new sample this cycle
//  cnt_in    in   WIDTH  sampled count value
//  dir_up    out  1      locked, counting up
//  dir_down  out  1      locked, counting down
//  locked    out  1      dir_up | dir_down
//  err       out  1      illegal-step flag (see CONFIGURATION)
//  seg       out  7      glyph: 7'b0111110 = 'U', 7'b1011110 = 'd', 7'b0000000 = blank
//  dp        out  1      tied to 1'b1
//
// BEHAVIOUR
//  - Reset (clr=1, any time, asynchronous):
//    state=EMPTY, prev=0, run=0, all outputs 0 except dp=1. seg=blank.
//  - All outputs are registered; they reflect a sample one cycle after the valid edge.
//    valid=0: no state change.
//  - Step class on valid: delta = cnt_in - prev (mod 2**WIDTH).
//    - delta=1 -> UP (includes wrap F->0).
//    - delta=2**WIDTH-1 -> DOWN (includes wrap 0->F).
//    - delta=0 -> HOLD.
//    - else -> JUMP.
//  - prev <= cnt_in on every valid sample.
//  - States and transitions (on valid):
//    - EMPTY: any sample -> TRACK, run=0. No class is evaluated.
//    - TRACK: UP/DOWN same as last direction -> run+1, else run=1 with the new direction.
//      When run reaches LOCK_CNT -> LOCK_UP or LOCK_DOWN. HOLD -> no change.
//    - LOCK_UP: UP or HOLD -> stay. DOWN -> TRACK, run=1, direction=down.
//    - LOCK_DOWN: mirror of LOCK_UP.
//    - Any state except EMPTY, JUMP with cnt_in==0 -> TRACK, run=0, no err.
//      This is treated as a counter clear (resync).
//    - Any state except EMPTY, JUMP with cnt_in!=0 -> TRACK, run=0, err asserted.
//  - dir_up=1 only in LOCK_UP; dir_down=1 only in LOCK_DOWN.
//    seg = 'U' / 'd' / blank accordingly.
//  - run saturates at LOCK_CNT. With LOCK_CNT=1, one step locks.
//
// CONFIGURATION
//  UDD_STICKY_ERR_EN defined:
//    err is sticky; it is set on an illegal jump and cleared only by clr.
//  UDD_STICKY_ERR_EN undefined:
//    err is a one-cycle pulse in the cycle after the offending sample.
//
// STRUCTURE
//  - udd_pkg: state enum {EMPTY,TRACK,LOCK_UP,LOCK_DOWN}, step enum {UP,DOWN,HOLD,JUMP},
//    and glyph constants SEG_U, SEG_D, SEG_BLANK.
//  - Sub-module udd_seg_enc: registered {dir_up,dir_down} -> seg glyph, combinational.
//
// TESTING
//  1. Reset, then valid samples 0,1,2,3 -> locked=1, dir_up=1, seg=7'b0111110
//     one cycle after the sample 3.
//  2. Samples 2,1,0,F,E -> lock DOWN after 0->F; seg=7'b1011110. No err on wrap.
//  3. Locked UP at 5, then sample 4 -> dir_up=0, locked=0, seg=blank.
//     Then 3,2 -> LOCK_DOWN.
//  4. Locked UP at 7, then sample 0 -> TRACK, err=0.
//     Then sample 9 -> err=1 (one cycle, or held until clr with UDD_STICKY_ERR_EN).
//  5. Samples 3,3,3 (HOLD) while locked -> outputs unchanged. valid=0 with a changing
//     cnt_in -> no change.
//  6. clr asserted mid-lock, between clock edges -> outputs clear immediately.
//     The first valid sample after release re-enters TRACK.

Source files
------------

// File: rtl/udd_pkg.sv
// udd_pkg: shared state/step enums and 7-seg glyph constants for up_down_detector.
package udd_pkg;
  typedef enum logic [1:0] {EMPTY, TRACK, LOCK_UP, LOCK_DOWN} state_e;
  typedef enum logic [1:0] {UP, DOWN, HOLD, JUMP} step_e;
  localparam logic [6:0] SEG_U     = 7'b0111110;
  localparam logic [6:0] SEG_D     = 7'b1011110;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;
endpackage

// File: rtl/udd_seg_enc.sv
// udd_seg_enc: maps registered direction flags to the 7-seg direction glyph.
module udd_seg_enc
  import udd_pkg::*;
(
  input  logic       dir_up,
  input  logic       dir_down,
  output logic [6:0] seg
);
  assign seg = dir_up ? SEG_U : dir_down ? SEG_D : SEG_BLANK;
endmodule

// File: rtl/up_down_detector.sv
// up_down_detector: infers count direction from a sampled counter stream and locks onto it.
// Define UDD_STICKY_ERR_EN to hold err until clr instead of pulsing it for one cycle.
module up_down_detector
  import udd_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int LOCK_CNT = 3
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             valid,
  input  logic [WIDTH-1:0] cnt_in,
  output logic             dir_up,
  output logic             dir_down,
  output logic             locked,
  output logic             err,
  output logic [6:0]       seg,
  output logic             dp
);
  localparam logic [3:0] LOCK = 4'(LOCK_CNT);
  state_e           state_q, state_d;
  logic [WIDTH-1:0] prev_q, prev_d, delta;
  logic [3:0]       run_q, run_d;
  logic             dn_q, dn_d, err_q, err_d, up_q, up_d, down_q, down_d, same;
  step_e            step;
  always_comb begin
    delta = cnt_in - prev_q;
    step = delta == WIDTH'(1) ? UP : delta == '1 ? DOWN : delta == '0 ? HOLD : JUMP;
    same = dn_q == (step == DOWN);
    state_d = state_q;
    prev_d = prev_q;
    run_d = run_q;
    dn_d = dn_q;
`ifdef UDD_STICKY_ERR_EN
    err_d = err_q;
`else
    err_d = 1'b0;
`endif
    if (valid) begin
      prev_d = cnt_in;
      if (state_q == EMPTY) begin
        state_d = TRACK;
        run_d = '0;
      end else if (step == JUMP) begin
        // a jump to zero is a counter clear on the far side, not an error
        state_d = TRACK;
        run_d = '0;
        err_d = err_d | (cnt_in != '0);
      end else if (step != HOLD && !(state_q != TRACK && same)) begin
        // run_q stays below LOCK while tracking, so the increment cannot overflow
        run_d = (state_q == TRACK && same) ? run_q + 4'd1 : 4'd1;
        dn_d = step == DOWN;
        state_d = run_d >= LOCK ? (step == DOWN ? LOCK_DOWN : LOCK_UP) : TRACK;
      end
    end
    up_d = state_d == LOCK_UP;
    down_d = state_d == LOCK_DOWN;
  end
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= EMPTY;
      prev_q <= '0;
      run_q <= '0;
      dn_q <= 1'b0;
      err_q <= 1'b0;
      up_q <= 1'b0;
      down_q <= 1'b0;
    end else begin
      state_q <= state_d;
      prev_q <= prev_d;
      run_q <= run_d;
      dn_q <= dn_d;
      err_q <= err_d;
      up_q <= up_d;
      down_q <= down_d;
    end
  end
  udd_seg_enc u_seg (
    .dir_up  (up_q),
    .dir_down(down_q),
    .seg     (seg)
  );
  assign dir_up = up_q;
  assign dir_down = down_q;
  assign locked = up_q | down_q;
  assign err = err_q;
  assign dp = 1'b1;
endmodule

// File: tb/tb_up_down_detector.sv
// tb_up_down_detector: directed stimulus against a streak-count model plus literal checks.
module tb_up_down_detector;
  localparam int L = 3;
  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic       valid = 1'b0;
  logic [3:0] cnt_in = 4'd0;
  logic       dir_up, dir_down, locked, err, dp;
  logic [6:0] seg;
  int checks = 0;
  int errors = 0;
  up_down_detector #(.WIDTH(4), .LOCK_CNT(L)) dut (
    .clk(clk), .clr(clr), .valid(valid), .cnt_in(cnt_in),
    .dir_up(dir_up), .dir_down(dir_down), .locked(locked),
    .err(err), .seg(seg), .dp(dp)
  );
  always #5 clk = ~clk;
  // model: direction is locked once the current same-direction streak reaches L
  int         streak;
  bit         sdn, seen, merr;
  logic [3:0] mprev;
  always @(posedge clk or posedge clr) begin
    if (clr) begin
      streak = 0; sdn = 0; seen = 0; merr = 0; mprev = 0;
    end else begin
      int d;
`ifndef UDD_STICKY_ERR_EN
      merr = 0;
`endif
      if (valid) begin
        d = (int'(cnt_in) - int'(mprev) + 16) % 16;
        if (!seen) begin
          seen = 1; streak = 0;
        end else if (d == 1 || d == 15) begin
          streak = (streak > 0 && sdn == (d == 15)) ? streak + 1 : 1;
          sdn = (d == 15);
        end else if (d != 0) begin
          streak = 0;
          if (cnt_in != 0) merr = 1;
        end
        mprev = cnt_in;
      end
    end
  end
  wire       eup   = streak >= L && !sdn;
  wire       edn   = streak >= L && sdn;
  wire [6:0] eseg  = eup ? 7'b0111110 : edn ? 7'b1011110 : 7'b0000000;
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  always @(negedge clk) begin
    check("m_dir_up", dir_up, eup);
    check("m_dir_down", dir_down, edn);
    check("m_locked", locked, eup | edn);
    check("m_seg", seg, eseg);
    check("m_err", err, merr);
    check("m_dp", dp, 1'b1);
  end
  task automatic samp(input logic [3:0] v);
    @(negedge clk); valid = 1'b1; cnt_in = v;
  endtask
  task automatic idle();
    @(negedge clk); valid = 1'b0;
  endtask
  task automatic reset();
    @(negedge clk); valid = 1'b0; clr = 1'b1;
    @(negedge clk); clr = 1'b0;
  endtask
  logic [3:0] vec [14] = '{4'd1, 4'd2, 4'd3, 4'd3, 4'd2, 4'd1, 4'd0, 4'd15,
                           4'd0, 4'd5, 4'd5, 4'd6, 4'd7, 4'd8};
  initial begin
    repeat (2) @(negedge clk);
    check("rst_locked", locked, 1'b0);
    check("rst_seg", seg, 7'b0000000);
    check("rst_dp", dp, 1'b1);
    check("rst_err", err, 1'b0);
    @(negedge clk); clr = 1'b0;
    samp(0); samp(1); samp(2); idle();
    check("t1_not_yet", locked, 1'b0);
    samp(3); idle();
    check("t1_dir_up", dir_up, 1'b1);
    check("t1_seg_u", seg, 7'b0111110);
    reset();
    samp(2); samp(1); samp(0); samp(15); idle();
    check("t2_dir_down", dir_down, 1'b1);
    check("t2_seg_d", seg, 7'b1011110);
    check("t2_no_err", err, 1'b0);
    samp(14); idle();
    check("t2_stay", dir_down, 1'b1);
    reset();
    samp(14); samp(15); samp(0); samp(1); idle();
    check("wrap_up", dir_up, 1'b1);
    reset();
    samp(2); samp(3); samp(4); samp(5); samp(4); idle();
    check("t3_unlock", locked, 1'b0);
    check("t3_blank", seg, 7'b0000000);
    samp(3); samp(2); idle();
    check("t3_lock_down", dir_down, 1'b1);
    reset();
    samp(9); idle();
    check("empty_no_err", err, 1'b0);
    reset();
    samp(4); samp(5); samp(6); samp(7); samp(0); idle();
    check("t4_resync_err", err, 1'b0);
    check("t4_resync_lock", locked, 1'b0);
    samp(9); idle();
    check("t4_err", err, 1'b1);
    idle();
`ifdef UDD_STICKY_ERR_EN
    check("t4_err_held", err, 1'b1);
`else
    check("t4_err_pulse", err, 1'b0);
`endif
    reset();
    samp(0); samp(1); samp(2); samp(3); samp(3); samp(3); samp(3); idle();
    check("t5_hold", dir_up, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); cnt_in = 4'(i * 5 + 9);
    end
    @(negedge clk);
    check("t5_novalid", dir_up, 1'b1);
    #2 clr = 1'b1;
    #1;
    check("t6_async_locked", locked, 1'b0);
    check("t6_async_seg", seg, 7'b0000000);
    check("t6_async_dp", dp, 1'b1);
    @(negedge clk); clr = 1'b0;
    samp(5); samp(6); samp(7); idle();
    check("t6_track", locked, 1'b0);
    samp(8); idle();
    check("t6_relock", dir_up, 1'b1);
    reset();
    foreach (vec[i]) samp(vec[i]);
    idle(); idle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
